rams_tdp_pipe_be: RTL and testbench

- Single-clock true dual-port RAM for the ORB pipeline (descriptor/keypoint buffers).
- Generalises the plain dual-port RAM with per-byte write enables, a selectable read-during-write mode, a configurable read latency with valid strobes, and deterministic same-address collision arbitration with a collision flag.
- Memory contents are not reset. Only the output and pipeline state are reset.

---
 rtl/rams_tdp_pipe_be_pkg.sv | 16 +
 rtl/rams_tdp_pipe_be_rd_pipe.sv | 35 +++
 rtl/rams_tdp_pipe_be.sv | 93 +++++++++
 tb/tb_rams_tdp_pipe_be.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rams_tdp_pipe_be_pkg.sv
// rams_tdp_pipe_be_pkg: read-mode constants, lane-count helper and byte-merge function for the TDP RAM.
package rams_pkg;
  localparam int RM_READ_FIRST = 0;
  localparam int RM_WRITE_FIRST = 1;
  localparam int RM_NO_CHANGE = 2;
  localparam int MAX_W = 256;
  function automatic int nbOf(input int width, input int byteW);
    return width / byteW;
  endfunction
  function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0] oldW, input logic [MAX_W-1:0] newW,
                                             input logic [MAX_W-1:0] we, input int byteW);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[8'(i)] = we[8'(i / byteW)] ? newW[8'(i)] : oldW[8'(i)];
    return r;
  endfunction
endpackage

// File: rtl/rams_tdp_pipe_be_rd_pipe.sv
// rams_rd_pipe: DEPTH-stage read data/valid delay line; each stage only loads data alongside a valid.
module rams_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vldIn,
  input  logic [WIDTH-1:0] dIn,
  output logic             vldOut,
  output logic [WIDTH-1:0] dOut
);
  if (DEPTH == 0) begin : gPass
    assign vldOut = vldIn;
    assign dOut = dIn;
  end else begin : gPipe
    localparam int DW = DEPTH * WIDTH;
    logic [DEPTH-1:0] v, srcV;
    logic [DEPTH-1:0][WIDTH-1:0] d, srcD;
    always_comb begin
      srcV = DEPTH'({v, vldIn});
      srcD = DW'({d, dIn});
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v <= '0;
        d <= '0;
      end else begin
        v <= srcV;
        for (int i = 0; i < DEPTH; i++) if (srcV[i]) d[i] <= srcD[i];
      end
    assign vldOut = v[DEPTH-1];
    assign dOut = d[DEPTH-1];
  end
endmodule

// File: rtl/rams_tdp_pipe_be.sv
// rams_tdp_pipe_be: true dual-port byte-enable RAM with READ_MODE, READ_LATENCY pipeline and collision flag.
// Define RAMS_TDP_BYPASS_EN to forward the post-write word to a port reading what the other port writes.
module rams_tdp_pipe_be
  import rams_pkg::*;
#(
  parameter int WIDTH_G = 32,
  parameter int SIZE = 64,
  parameter int ADDRWIDTH = 6,
  parameter int BYTE_W = 8,
  parameter int READ_LATENCY = 1,
  parameter int READ_MODE = 0,
  parameter INIT_FILE = "NONE"
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enA,
  input  logic [nbOf(WIDTH_G, BYTE_W)-1:0]  weA,
  input  logic [ADDRWIDTH-1:0]              addrA,
  input  logic [WIDTH_G-1:0]                diA,
  output logic [WIDTH_G-1:0]                doA,
  output logic                              vldA,
  input  logic                              enB,
  input  logic [nbOf(WIDTH_G, BYTE_W)-1:0]  weB,
  input  logic [ADDRWIDTH-1:0]              addrB,
  input  logic [WIDTH_G-1:0]                diB,
  output logic [WIDTH_G-1:0]                doB,
  output logic                              vldB,
  output logic                              collision
);
  localparam int NB = nbOf(WIDTH_G, BYTE_W);
  function automatic logic [WIDTH_G-1:0] mrg(input logic [WIDTH_G-1:0] o, input logic [WIDTH_G-1:0] n,
                                             input logic [NB-1:0] we);
    return WIDTH_G'(merge(MAX_W'(o), MAX_W'(n), MAX_W'(we), BYTE_W));
  endfunction
  logic [WIDTH_G-1:0] mem [SIZE];
  logic inA, inB, same, anyA, anyB, wrA, wrB, wwColl, rdA, rdB, s1VA, s1VB;
  logic [WIDTH_G-1:0] oldA, oldB, mrgA, mrgB, both, postA, postB, xA, xB, s1InA, s1InB, s1DA, s1DB;
  always_comb begin
    inA = 32'(addrA) < SIZE;
    inB = 32'(addrB) < SIZE;
    same = addrA == addrB;
    anyA = enA && |weA;
    anyB = enB && |weB;
    wrA = anyA && inA;
    wrB = anyB && inB;
    wwColl = anyA && anyB && same;
    oldA = inA ? mem[addrA] : '0;
    oldB = inB ? mem[addrB] : '0;
    mrgA = mrg(oldA, diA, weA);
    mrgB = mrg(oldB, diB, weB);
    // A is merged over B so A owns every lane both ports write
    both = mrg(mrgB, diA, weA);
    postA = wwColl ? both : mrgA;
    postB = wwColl ? both : mrgB;
`ifdef RAMS_TDP_BYPASS_EN
    xA = anyB && same ? mrgB : oldA;
    xB = anyA && same ? mrgA : oldB;
`else
    xA = oldA;
    xB = oldB;
`endif
    s1InA = !inA ? '0 : anyA ? (READ_MODE == RM_WRITE_FIRST ? postA : oldA) : xA;
    s1InB = !inB ? '0 : anyB ? (READ_MODE == RM_WRITE_FIRST ? postB : oldB) : xB;
    rdA = enA && !(READ_MODE == RM_NO_CHANGE && anyA);
    rdB = enB && !(READ_MODE == RM_NO_CHANGE && anyB);
  end
  // Contents are never reset; the reset only blocks writes
  always_ff @(posedge clk or posedge rst)
    if (!rst) begin
      if (wrB && !wwColl) mem[addrB] <= mrgB;
      if (wrA) mem[addrA] <= postA;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1VA <= 1'b0;
      s1VB <= 1'b0;
      s1DA <= '0;
      s1DB <= '0;
      collision <= 1'b0;
    end else begin
      s1VA <= rdA;
      s1VB <= rdB;
      if (rdA) s1DA <= s1InA;
      if (rdB) s1DB <= s1InB;
      collision <= wwColl;
    end
  rams_rd_pipe #(.WIDTH(WIDTH_G), .DEPTH(READ_LATENCY - 1)) uPipeA (
    .clk(clk), .rst(rst), .vldIn(s1VA), .dIn(s1DA), .vldOut(vldA), .dOut(doA)
  );
  rams_rd_pipe #(.WIDTH(WIDTH_G), .DEPTH(READ_LATENCY - 1)) uPipeB (
    .clk(clk), .rst(rst), .vldIn(s1VB), .dIn(s1DB), .vldOut(vldB), .dOut(doB)
  );
endmodule

// File: tb/tb_rams_tdp_pipe_be.sv
// tb_rams_tdp_pipe_be: three RAM instances (modes 0/1/2, latencies 2/1/3) against a word-array reference model.
module tb_rams_tdp_pipe_be;
  localparam int SZ = 48;
  localparam int N = 3;
  localparam int MAXC = 1024;
  localparam int LAT [N] = '{2, 1, 3};
`ifdef RAMS_TDP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enA = 1'b0, enB = 1'b0;
  logic [3:0] weA = '0, weB = '0;
  logic [5:0] addrA = '0, addrB = '0;
  logic [31:0] diA = '0, diB = '0;
  logic [31:0] doA [N], doB [N];
  logic vldA [N], vldB [N], coll [N];
  always #5 clk = ~clk;
  for (genvar k = 0; k < N; k++) begin : gDut
    rams_tdp_pipe_be #(.WIDTH_G(32), .SIZE(SZ), .ADDRWIDTH(6), .BYTE_W(8), .READ_LATENCY(LAT[k]),
                       .READ_MODE(k), .INIT_FILE("NONE")) uDut (
      .clk(clk), .rst(rst),
      .enA(enA), .weA(weA), .addrA(addrA), .diA(diA), .doA(doA[k]), .vldA(vldA[k]),
      .enB(enB), .weB(weB), .addrB(addrB), .diB(diB), .doB(doB[k]), .vldB(vldB[k]),
      .collision(coll[k])
    );
  end
  logic [31:0] mm [SZ];
  bit mk [SZ];
  bit evA [N][MAXC], evB [N][MAXC], ekA [N][MAXC], ekB [N][MAXC], ecol [MAXC];
  logic [31:0] edA [N][MAXC], edB [N][MAXC];
  logic [31:0] lastA [N], lastB [N];
  bit knownA [N], knownB [N];
  int cyc = 0, errors = 0, checks = 0;
  function automatic logic [31:0] put(input logic [31:0] w, input logic [3:0] we, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  task automatic sched(input int k, input bit portB, input logic [31:0] v, input bit kn);
    int due;
    due = cyc + LAT[k];
    if (portB) begin
      evB[k][due] = 1'b1; edB[k][due] = v; ekB[k][due] = kn;
    end else begin
      evA[k][due] = 1'b1; edA[k][due] = v; ekA[k][due] = kn;
    end
  endtask
  task automatic model();
    logic [31:0] oA, oB, nA, nB;
    bit iA, iB, wA, wB, koA, koB, knA, knB;
    if (rst) return;
    iA = int'(addrA) < SZ;
    iB = int'(addrB) < SZ;
    wA = enA && weA != 4'h0;
    wB = enB && weB != 4'h0;
    oA = iA ? mm[addrA] : 32'h0;
    oB = iB ? mm[addrB] : 32'h0;
    koA = !iA || mk[addrA];
    koB = !iB || mk[addrB];
    if (wB && iB) begin
      mm[addrB] = put(mm[addrB], weB, diB);
      mk[addrB] = mk[addrB] || weB == 4'hf;
    end
    if (wA && iA) begin
      mm[addrA] = put(mm[addrA], weA, diA);
      mk[addrA] = mk[addrA] || weA == 4'hf;
    end
    nA = iA ? mm[addrA] : 32'h0;
    nB = iB ? mm[addrB] : 32'h0;
    knA = !iA || mk[addrA];
    knB = !iB || mk[addrB];
    ecol[cyc+1] = wA && wB && addrA == addrB;
    for (int k = 0; k < N; k++) begin
      if (enA && !(k == 2 && wA))
        sched(k, 1'b0, wA ? (k == 1 ? nA : oA) : (BYP ? nA : oA), wA ? (k == 1 ? knA : koA) : (BYP ? knA : koA));
      if (enB && !(k == 2 && wB))
        sched(k, 1'b1, wB ? (k == 1 ? nB : oB) : (BYP ? nB : oB), wB ? (k == 1 ? knB : koB) : (BYP ? knB : koB));
    end
  endtask
  task automatic check();
    for (int k = 0; k < N; k++) begin
      if (evA[k][cyc]) begin lastA[k] = edA[k][cyc]; knownA[k] = ekA[k][cyc]; end
      if (evB[k][cyc]) begin lastB[k] = edB[k][cyc]; knownB[k] = ekB[k][cyc]; end
      chk($sformatf("vldA%0d@%0d", k, cyc), 32'(vldA[k]), 32'(evA[k][cyc]));
      chk($sformatf("vldB%0d@%0d", k, cyc), 32'(vldB[k]), 32'(evB[k][cyc]));
      if (knownA[k]) chk($sformatf("doA%0d@%0d", k, cyc), doA[k], lastA[k]);
      if (knownB[k]) chk($sformatf("doB%0d@%0d", k, cyc), doB[k], lastB[k]);
      chk($sformatf("coll%0d@%0d", k, cyc), 32'(coll[k]), 32'(ecol[cyc]));
    end
  endtask
  task automatic step();
    model();
    @(posedge clk);
    cyc++;
    #1;
    check();
  endtask
  task automatic drive(input logic ea, input logic [3:0] wa, input logic [5:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [5:0] ab, input logic [31:0] db);
    enA = ea; weA = wa; addrA = aa; diA = da;
    enB = eb; weB = wb; addrB = ab; diB = db;
    step();
  endtask
  task automatic idle();
    drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
  endtask
  initial begin
    logic [5:0] a;
    for (int k = 0; k < N; k++) begin
      lastA[k] = '0; lastB[k] = '0; knownA[k] = 1'b1; knownB[k] = 1'b1;
    end
    for (int i = 0; i < SZ; i++) mk[i] = 1'b0;
    idle();
    idle();
    rst = 1'b0;
    for (int i = 0; i < SZ; i += 2)
      drive(1'b1, 4'hf, 6'(i), $urandom, 1'b1, 4'hf, 6'(i + 1), $urandom);
    idle();
    // latency and basic write/read
    drive(1'b1, 4'hf, 6'd5, 32'hDEADBEEF, 1'b0, 4'h0, 6'd0, 32'h0);
    drive(1'b1, 4'h0, 6'd5, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    chk("lat1_do", doA[1], 32'hDEADBEEF);
    idle();
    chk("lat2_vld", 32'(vldA[0]), 32'd1);
    chk("lat2_do", doA[0], 32'hDEADBEEF);
    idle();
    chk("lat2_vld_low", 32'(vldA[0]), 32'd0);
    // byte enables
    drive(1'b1, 4'hf, 6'd3, 32'h11223344, 1'b0, 4'h0, 6'd0, 32'h0);
    drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'b0101, 6'd3, 32'hAABBCCDD);
    drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd3, 32'h0);
    chk("byte_en", doB[1], 32'h11BB33DD);
    // read-during-write modes
    drive(1'b1, 4'hf, 6'd7, 32'h1, 1'b0, 4'h0, 6'd0, 32'h0);
    drive(1'b1, 4'hf, 6'd7, 32'h2, 1'b0, 4'h0, 6'd0, 32'h0);
    chk("write_first", doA[1], 32'h2);
    idle();
    chk("read_first", doA[0], 32'h1);
    idle();
    chk("no_change_vld", 32'(vldA[2]), 32'd0);
    chk("no_change_hold", doA[2], 32'hDEADBEEF);
    drive(1'b1, 4'h0, 6'd7, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    chk("mode_mem", doA[1], 32'h2);
    // write/write collision
    drive(1'b1, 4'b0011, 6'd9, 32'hAAAAAAAA, 1'b1, 4'hf, 6'd9, 32'hBBBBBBBB);
    chk("ww_coll", 32'(coll[0]), 32'd1);
    drive(1'b1, 4'h0, 6'd9, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    chk("ww_pulse", 32'(coll[0]), 32'd0);
    chk("ww_merge", doA[1], 32'hBBBBAAAA);
    // cross-port read/write
    drive(1'b1, 4'hf, 6'd4, 32'h9, 1'b0, 4'h0, 6'd0, 32'h0);
    drive(1'b1, 4'hf, 6'd4, 32'h5, 1'b1, 4'h0, 6'd4, 32'h0);
    chk("xport_coll", 32'(coll[0]), 32'd0);
    chk("xport_read", doB[1], BYP ? 32'h5 : 32'h9);
    // out of range
    drive(1'b1, 4'hf, 6'd50, 32'hCAFEF00D, 1'b1, 4'h0, 6'd50, 32'h0);
    chk("oor_vld", 32'(vldB[1]), 32'd1);
    chk("oor_do", doB[1], 32'h0);
    idle();
    idle();
    for (int i = 0; i < 300; i++) begin
      a = 6'($urandom_range(0, 63));
      drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'h0, a, $urandom,
            1'($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'h0,
            $urandom_range(0, 3) == 0 ? a : 6'($urandom_range(0, 63)), $urandom);
    end
    idle();
    idle();
    idle();
    // reset with reads in flight
    drive(1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 4'h0, 6'd3, 32'h0);
    drive(1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 4'h0, 6'd3, 32'h0);
    rst = 1'b1;
    for (int i = cyc + 1; i < MAXC; i++) begin
      ecol[i] = 1'b0;
      for (int k = 0; k < N; k++) begin evA[k][i] = 1'b0; evB[k][i] = 1'b0; end
    end
    for (int k = 0; k < N; k++) begin
      lastA[k] = '0; lastB[k] = '0; knownA[k] = 1'b1; knownB[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_vldA%0d", k), 32'(vldA[k]), 32'd0);
      chk($sformatf("rst_vldB%0d", k), 32'(vldB[k]), 32'd0);
      chk($sformatf("rst_doA%0d", k), doA[k], 32'h0);
      chk($sformatf("rst_doB%0d", k), doB[k], 32'h0);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 4'hf, 6'd5, 32'h12345678, 1'b1, 4'hf, 6'd3, 32'h87654321);
    rst = 1'b0;
    drive(1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 4'h0, 6'd3, 32'h0);
    for (int i = 0; i < 4; i++) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
